// File: rtl/challengeqsys_s2r_pkg.sv
// Shared definitions for the stream-to-RAM writer: FSM states, default sizing, byte-lane helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package challengeqsys_s2r_pkg;

  localparam int S2R_DEPTH_WORDS = 4942;
  localparam int S2R_ADDR_W      = 13;
  localparam int S2R_FIFO_DEPTH  = 4;
  // FIFO entry: {byteenable[3:0], data[31:0]}
  localparam int S2R_FIFO_W      = 36;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WRITE,
    S_DRAIN,
    S_DONE
  } s2r_state_t;

  // Zero every byte lane whose enable bit is clear.
  function automatic logic [31:0] s2r_mask_bytes(input logic [31:0] dat, input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = be[i] ? dat[i*8 +: 8] : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/challengeqsys_s2r_fifo.sv
// Synchronous skid FIFO, DEPTH x WIDTH, head word visible combinationally on pop_dat.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored; full/empty flags let the caller throttle.
// Ports: clk, reset_n (async, active-low, flushes), push/push_dat, pop/pop_dat, full, empty.
module challengeqsys_s2r_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only consumed while not empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/challengeqsys_stream_to_ram.sv
// Captures one sop..eop stream packet into a word-addressed RAM from a start-latched base, with a word limit.
// Latency: a word accepted at cycle N into an empty FIFO is written at cycle N+1.
// Backpressure: snk_ready drops only when the skid FIFO is full or the terminating word is already taken.
// Ports: clk, reset_n; start/base_addr/max_words control; snk_* stream sink; mem_* RAM write master;
//        busy, done (1-cycle pulse), word_count, trunc_err (sticky).
// Optional: define S2R_CHECKSUM_EN to add output checksum[31:0] (sum of written words, disabled bytes zeroed).
module challengeqsys_stream_to_ram
  import challengeqsys_s2r_pkg::*;
#(
  parameter int DEPTH_WORDS = S2R_DEPTH_WORDS,
  parameter int ADDR_W      = S2R_ADDR_W,
  parameter int FIFO_DEPTH  = S2R_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] max_words,
  input  logic [31:0]       snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic              snk_sop,
  input  logic              snk_eop,
  input  logic [1:0]        snk_empty,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count,
  output logic              trunc_err
`ifdef S2R_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  s2r_state_t              state;
  logic [ADDR_W-1:0]       wr_addr;
  logic [ADDR_W-1:0]       max_r;
  logic [ADDR_W-1:0]       acc_cnt;
  logic [ADDR_W-1:0]       acc_next;
  // Set once the terminating word has been taken; the FSM then only waits for the FIFO to drain.
  logic                    term;
  logic                    accept;
  logic                    push;
  logic [3:0]              push_be;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [S2R_FIFO_W-1:0]   fifo_out;

  always_comb begin
    snk_ready = 1'b0;
    case (state)
      S_ARMED: snk_ready = 1'b1;
      S_WRITE: snk_ready = !fifo_full && !term;
      S_DRAIN: snk_ready = !term;
      default: snk_ready = 1'b0;
    endcase
  end

  assign accept   = snk_valid && snk_ready;
  // In ARMED only the sop word is kept; in DRAIN everything is dropped.
  assign push     = accept && ((state == S_ARMED && snk_sop) || state == S_WRITE);
  assign push_be  = snk_eop ? (4'hF >> snk_empty) : 4'hF;
  assign acc_next = acc_cnt + ONE;

  challengeqsys_s2r_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (S2R_FIFO_W)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat ({push_be, snk_data}),
    .pop      (!fifo_empty),
    .pop_dat  (fifo_out),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // The FIFO head is written straight out; every RAM output is zero when nothing is pending.
  assign mem_write      = !fifo_empty;
  assign mem_chipselect = !fifo_empty;
  assign mem_address    = fifo_empty ? '0 : wr_addr;
  assign mem_writedata  = fifo_empty ? '0 : fifo_out[31:0];
  assign mem_byteenable = fifo_empty ? '0 : fifo_out[35:32];
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wr_addr    <= '0;
      max_r      <= '0;
      acc_cnt    <= '0;
      term       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
      trunc_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      // Address wraps at the RAM end, or at ADDR_W overflow when the base lies beyond it.
      if (mem_write) begin
        wr_addr    <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ONE;
        word_count <= word_count + ONE;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            wr_addr    <= base_addr;
            max_r      <= max_words;
            acc_cnt    <= '0;
            term       <= 1'b0;
            word_count <= '0;
            trunc_err  <= 1'b0;
            busy       <= 1'b1;
            if (max_words == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ARMED;
            end
          end
        end
        S_ARMED: begin
          if (accept && snk_sop) begin
            acc_cnt <= ONE;
            if (snk_eop) begin
              term  <= 1'b1;
              state <= S_WRITE;
            end else if (max_r == ONE) begin
              trunc_err <= 1'b1;
              state     <= S_DRAIN;
            end else begin
              state <= S_WRITE;
            end
          end
        end
        S_WRITE, S_DRAIN: begin
          if (term) begin
            if (fifo_empty) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else if (accept) begin
            if (state == S_WRITE) begin
              acc_cnt <= acc_next;
              if (snk_eop) begin
                term <= 1'b1;
              end else if (acc_next == max_r) begin
                trunc_err <= 1'b1;
                state     <= S_DRAIN;
              end
            end else if (snk_eop) begin
              term <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef S2R_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (state == S_IDLE && start) begin
      checksum <= '0;
    end else if (mem_write) begin
      checksum <= checksum + s2r_mask_bytes(mem_writedata, mem_byteenable);
    end
  end
`endif

endmodule

// File: tb/tb_challengeqsys_stream_to_ram.sv
// Scoreboard bench for the stream-to-RAM writer: packets are modelled into an expected-write queue.
// Latency: n/a.
// Backpressure: the driver holds each word until snk_ready is seen.
`timescale 1ns/1ps
module tb_challengeqsys_stream_to_ram;

  localparam int AW    = 13;
  localparam int DEPTH = 4942;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] max_words = '0;
  logic [31:0]   snk_data = '0;
  logic          snk_valid = 1'b0;
  logic          snk_sop = 1'b0;
  logic          snk_eop = 1'b0;
  logic [1:0]    snk_empty = '0;
  logic          snk_ready;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect;
  logic          mem_write;
  logic [3:0]    mem_byteenable;
  logic [31:0]   mem_writedata;
  logic          mem_clken;
  logic          busy;
  logic          done;
  logic [AW-1:0] word_count;
  logic          trunc_err;
`ifdef S2R_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  challengeqsys_stream_to_ram dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .max_words      (max_words),
    .snk_data       (snk_data),
    .snk_valid      (snk_valid),
    .snk_ready      (snk_ready),
    .snk_sop        (snk_sop),
    .snk_eop        (snk_eop),
    .snk_empty      (snk_empty),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .busy           (busy),
    .done           (done),
    .word_count     (word_count),
    .trunc_err      (trunc_err)
`ifdef S2R_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    bit          sop;
    bit          eop;
    logic [1:0]  empty;
  } sw_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } wr_t;

  sw_t         pkt[$];
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          wr_seen = 0;
  logic [31:0] cksum_exp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (be[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) done_cnt++;
      if (mem_write) begin
        wr_seen++;
        chk("write_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", mem_address, mon_e.addr);
          chk("wr_data", mem_writedata, mon_e.data);
          chk("wr_be", mem_byteenable, mon_e.be);
          chk("wr_cs", mem_chipselect, 1);
          cksum_exp = cksum_exp + (mon_e.data & lane_mask(mon_e.be));
        end
      end
    end
  end

  // Reference model: writes follow from the packet rules alone.
  function automatic void build_expect(input logic [AW-1:0] b, input logic [AW-1:0] m,
                                       output int nexp, output bit trunc);
    logic [AW-1:0] a;
    bit in_pkt;
    bit stop;
    int k;
    wr_t e;
    a = b; in_pkt = 0; stop = 0; k = 0; trunc = 0; nexp = 0;
    if (m == 0) return;
    for (int i = 0; i < pkt.size(); i++) begin
      if (stop) break;
      if (!in_pkt && !pkt[i].sop) continue;
      in_pkt = 1;
      e.addr = a;
      e.data = pkt[i].d;
      e.be   = pkt[i].eop ? (4'hF >> pkt[i].empty) : 4'hF;
      exp_q.push_back(e);
      k++;
      a = (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
      if (pkt[i].eop) stop = 1;
      else if (k == int'(m)) begin trunc = 1; stop = 1; end
    end
    nexp = k;
  endfunction

  function automatic void build_pkt(input int ngarb, input int len, input logic [31:0] d0,
                                    input bit rnd, input logic [1:0] emp);
    sw_t w;
    pkt.delete();
    for (int i = 0; i < ngarb; i++) begin
      w.d = $urandom; w.sop = 0; w.eop = 0; w.empty = 2'($urandom_range(0, 3));
      pkt.push_back(w);
    end
    for (int i = 0; i < len; i++) begin
      w.d = rnd ? $urandom : d0 + 32'(i);
      w.sop = (i == 0);
      w.eop = (i == len - 1);
      w.empty = w.eop ? emp : 2'($urandom_range(0, 3));
      pkt.push_back(w);
    end
  endfunction

  task automatic send_word(input sw_t w);
    int t;
    bit acc;
    t = 0; acc = 0;
    snk_valid = 1; snk_data = w.d; snk_sop = w.sop; snk_eop = w.eop; snk_empty = w.empty;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = snk_ready;
      @(posedge clk);
      #1;
      t++;
    end
    snk_valid = 0; snk_sop = 0; snk_eop = 0;
    chk("word_accepted", acc, 1);
  endtask

  // gap: 0 none, 1 always one idle cycle, 2 random. poke: word index before which a stray start is issued.
  task automatic send_pkt(input int gap, input int poke, input int stop_after);
    for (int i = 0; i < pkt.size(); i++) begin
      if (i == stop_after) break;
      if (i == poke) begin
        start = 1; base_addr = 13'h155; max_words = 13'd1;
        @(posedge clk); #1;
        start = 0;
      end
      send_word(pkt[i]);
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] m);
    cksum_exp = '0;
    start = 1; base_addr = b; max_words = m;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done_and_check(input int nexp, input bit trunc);
    int t;
    int d0;
    t = 0; d0 = done_cnt;
    while (done_cnt == d0 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_after_done", busy, 0);
    chk("word_count", word_count, nexp);
    chk("trunc_err", trunc_err, trunc);
    chk("scoreboard_drained", exp_q.size(), 0);
`ifdef S2R_CHECKSUM_EN
    chk("checksum", checksum, cksum_exp);
`endif
  endtask

  task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] m, input int gap, input int poke);
    int nexp;
    bit trunc;
    build_expect(b, m, nexp, trunc);
    do_start(b, m);
    if (m != 0) send_pkt(gap, poke, -1);
    wait_done_and_check(nexp, trunc);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_snk_ready"}, snk_ready, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_cs"}, mem_chipselect, 0);
    chk({tag, "_mem_addr"}, mem_address, 0);
    chk({tag, "_mem_be"}, mem_byteenable, 0);
    chk({tag, "_mem_wdata"}, mem_writedata, 0);
    chk({tag, "_mem_clken"}, mem_clken, 1);
    chk({tag, "_word_count"}, word_count, 0);
    chk({tag, "_trunc_err"}, trunc_err, 0);
`ifdef S2R_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] rb;
    logic [AW-1:0] rm;
    int            rl;
    int            rg;
    int            w0;
    int            nexp;
    bit            trunc;

    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("in_reset");
    reset_n = 1;
    @(posedge clk); #1;
    check_idle_outputs("after_reset");

    // 4-word packet, eop with one unused byte.
    build_pkt(0, 4, 32'hA0, 0, 2'd1);
    run(13'h10, 13'd8, 0, -1);

    // RAM end wrap: 4940, 4941, 0, 1, 2.
    build_pkt(0, 5, 32'hB0, 0, 2'd0);
    run(13'd4940, 13'd8, 2, -1);

    // ADDR_W overflow wrap from a base beyond the RAM.
    build_pkt(0, 4, 32'hB8, 0, 2'd3);
    run(13'd8190, 13'd8, 0, -1);

    // Limit of 3 on a 6-word packet.
    build_pkt(0, 6, 32'hD0, 0, 2'd2);
    run(13'h40, 13'd3, 0, -1);

    // Limit hit exactly on the eop word: no truncation.
    build_pkt(0, 3, 32'hD8, 0, 2'd0);
    run(13'h48, 13'd3, 1, -1);

    // Garbage before sop, plus a start while busy that must be ignored.
    build_pkt(2, 5, 32'hC0, 0, 2'd0);
    run(13'h100, 13'd8, 0, 3);

    // Single-word packet and a one-word limit.
    build_pkt(1, 1, 32'hE0, 0, 2'd2);
    run(13'h200, 13'd4, 0, -1);
    build_pkt(0, 4, 32'hE8, 0, 2'd0);
    run(13'h210, 13'd1, 0, -1);

    // Zero limit: immediate completion, nothing written.
    build_pkt(0, 2, 32'hF0, 0, 2'd0);
    run(13'h300, 13'd0, 0, -1);

    // Reset mid-packet with one-cycle gaps; then a new transfer.
    build_pkt(0, 8, 32'h600, 0, 2'd0);
    build_expect(13'h20, 13'd20, nexp, trunc);
    do_start(13'h20, 13'd20);
    send_pkt(1, -1, 4);
    snk_valid = 1; snk_data = 32'hDEAD; snk_sop = 0; snk_eop = 0;
    reset_n = 0;
    exp_q.delete();
    cksum_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    snk_valid = 0;
    reset_n = 1;
    w0 = wr_seen;
    check_idle_outputs("mid_pkt_reset");
    repeat (6) begin @(posedge clk); #1; end
    chk("no_write_after_reset", wr_seen - w0, 0);
    chk("busy_after_reset", busy, 0);
    build_pkt(1, 3, 32'h700, 0, 2'd1);
    run(13'h30, 13'd8, 0, -1);

`ifdef S2R_CHECKSUM_EN
    pkt.delete();
    pkt.push_back('{d: 32'h1, sop: 1, eop: 0, empty: 2'd0});
    pkt.push_back('{d: 32'h2, sop: 0, eop: 0, empty: 2'd0});
    pkt.push_back('{d: 32'hFFFF_FFFF, sop: 0, eop: 1, empty: 2'd0});
    run(13'h50, 13'd8, 0, -1);
    chk("checksum_wrap", checksum, 32'h0000_0002);
`endif

    // Randomized packets around both wrap points and the body of the RAM.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       rb = AW'($urandom_range(4935, 4941));
        1:       rb = AW'($urandom_range(8186, 8191));
        default: rb = AW'($urandom_range(0, 4941));
      endcase
      rm = AW'($urandom_range(1, 9));
      rl = $urandom_range(1, 10);
      rg = $urandom_range(0, 3);
      build_pkt(rg, rl, 32'h0, 1, 2'($urandom_range(0, 3)));
      run(rb, rm, 2, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
